// File: rtl/alarm_scheduler.sv
// alarm_scheduler: time-of-day keeper plus alarm sequencer.
// Counts seconds/minutes/hours from a one-cycle tick strobe, holds an alarm
// time, and emits a single-cycle H trigger when the armed alarm minute is
// reached. Ringing ends on dismiss, on auto-timeout, or (optionally) snooze.
// Optional feature macro: ALARM_SNOOZE_EN enables the snooze input, the
// SNOOZE state (encoding 11) and its minute counter. Without it the snooze
// input is ignored and encoding 11 falls back to IDLE on the next edge.
module alarm_scheduler #(
  parameter int TICKS_PER_MIN = 60,
  parameter int TIMEOUT_MIN   = 10,
  parameter int SNOOZE_MIN    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       arm,
  input  logic       load_time,
  input  logic       load_alarm,
  input  logic [4:0] set_hh,
  input  logic [5:0] set_mm,
  input  logic       dismiss,
  input  logic       snooze,
  output logic       H,
  output logic       ringing,
  output logic [4:0] time_hh,
  output logic [5:0] time_mm,
  output logic       bad_load,
  output logic [1:0] sched_state
);

  localparam int SEC_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(TICKS_PER_MIN - 1);
  localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);
  // Counters hold "minutes already elapsed"; the last value means the
  // current minute event is the final one.
  localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT_MIN - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_RINGING = 2'b10,
    ST_SNOOZE  = 2'b11
  } state_t;

  // Timebase and alarm registers
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [4:0]       hh_q, hh_d;
  logic [5:0]       mm_q, mm_d;
  logic [4:0]       alarm_hh_q;
  logic [5:0]       alarm_mm_q;
  logic             bad_load_q;

  // Sequencer registers
  state_t           state_q;
  logic             h_q;
  logic             ringing_q;
  logic [5:0]       ring_cnt_q;

  // Decoded events
  logic             set_ok;
  logic             time_load_ok;
  logic             min_evt;
  logic             match;
  logic [4:0]       next_hh;
  logic [5:0]       next_mm;

  assign set_ok       = (set_hh <= 5'd23) && (set_mm <= 6'd59);
  assign time_load_ok = load_time && set_ok;

  // A valid time load swallows a coincident tick, so it can never create a
  // minute event. A rejected load leaves the timebase running untouched.
  assign min_evt = tick && !time_load_ok && (sec_q == SEC_LAST);

  // Only the rollover into the alarm minute matches; the alarm registers
  // used here are the pre-load values when load_alarm coincides.
  assign match = min_evt && (next_hh == alarm_hh_q) && (next_mm == alarm_mm_q);

  // Wall-clock time one minute ahead of the current hh:mm.
  always_comb begin
    next_mm = mm_q + 6'd1;
    next_hh = hh_q;
    if (mm_q == 6'd59) begin
      next_mm = 6'd0;
      next_hh = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
    end
  end

  // Next-state of the seconds/minutes/hours timebase.
  always_comb begin
    sec_d = sec_q;
    hh_d  = hh_q;
    mm_d  = mm_q;
    if (time_load_ok) begin
      hh_d  = set_hh;
      mm_d  = set_mm;
      sec_d = '0;
    end else if (tick) begin
      if (sec_q == SEC_LAST) begin
        sec_d = '0;
        hh_d  = next_hh;
        mm_d  = next_mm;
      end else begin
        sec_d = sec_q + SEC_ONE;
      end
    end
  end

  // Timebase, alarm time and load-error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q      <= '0;
      hh_q       <= 5'd0;
      mm_q       <= 6'd0;
      alarm_hh_q <= 5'd0;
      alarm_mm_q <= 6'd0;
      bad_load_q <= 1'b0;
    end else begin
      sec_q      <= sec_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      bad_load_q <= (load_time || load_alarm) && !set_ok;
      if (load_alarm && set_ok) begin
        alarm_hh_q <= set_hh;
        alarm_mm_q <= set_mm;
      end
    end
  end

`ifdef ALARM_SNOOZE_EN
  localparam logic [5:0] SNOOZE_LAST = 6'(SNOOZE_MIN - 1);
  logic [5:0] snz_cnt_q;

  // Alarm sequencer: arm gate, dismiss, snooze, timeout/expiry, then match.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      h_q        <= 1'b0;
      ringing_q  <= 1'b0;
      ring_cnt_q <= 6'd0;
      snz_cnt_q  <= 6'd0;
    end else begin
      h_q <= 1'b0;
      if (!arm) begin
        state_q   <= ST_IDLE;
        ringing_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q   <= ST_ARMED;
            ringing_q <= 1'b0;
          end
          ST_ARMED: begin
            if (match) begin
              state_q    <= ST_RINGING;
              ringing_q  <= 1'b1;
              h_q        <= 1'b1;
              ring_cnt_q <= 6'd0;
            end
          end
          ST_RINGING: begin
            if (dismiss) begin
              state_q   <= ST_ARMED;
              ringing_q <= 1'b0;
            end else if (snooze) begin
              state_q   <= ST_SNOOZE;
              ringing_q <= 1'b0;
              snz_cnt_q <= 6'd0;
            end else if (min_evt) begin
              if (ring_cnt_q == TIMEOUT_LAST) begin
                state_q   <= ST_ARMED;
                ringing_q <= 1'b0;
              end else begin
                ring_cnt_q <= ring_cnt_q + 6'd1;
              end
            end
          end
          ST_SNOOZE: begin
            // A repeated snooze press while already snoozing has no effect.
            if (dismiss) begin
              state_q <= ST_ARMED;
            end else if (min_evt) begin
              if (snz_cnt_q == SNOOZE_LAST) begin
                state_q    <= ST_RINGING;
                ringing_q  <= 1'b1;
                h_q        <= 1'b1;
                ring_cnt_q <= 6'd0;
              end else begin
                snz_cnt_q <= snz_cnt_q + 6'd1;
              end
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            ringing_q <= 1'b0;
          end
        endcase
      end
    end
  end
`else
  // The snooze input and length have no function in this build.
  logic unused_snooze;
  assign unused_snooze = &{1'b0, snooze, 6'(SNOOZE_MIN)};

  // Alarm sequencer: arm gate, dismiss, timeout, then match.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      h_q        <= 1'b0;
      ringing_q  <= 1'b0;
      ring_cnt_q <= 6'd0;
    end else begin
      h_q <= 1'b0;
      if (!arm) begin
        state_q   <= ST_IDLE;
        ringing_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q   <= ST_ARMED;
            ringing_q <= 1'b0;
          end
          ST_ARMED: begin
            if (match) begin
              state_q    <= ST_RINGING;
              ringing_q  <= 1'b1;
              h_q        <= 1'b1;
              ring_cnt_q <= 6'd0;
            end
          end
          ST_RINGING: begin
            if (dismiss) begin
              state_q   <= ST_ARMED;
              ringing_q <= 1'b0;
            end else if (min_evt) begin
              if (ring_cnt_q == TIMEOUT_LAST) begin
                state_q   <= ST_ARMED;
                ringing_q <= 1'b0;
              end else begin
                ring_cnt_q <= ring_cnt_q + 6'd1;
              end
            end
          end
          // Encoding 11 is illegal here; recover to IDLE.
          default: begin
            state_q   <= ST_IDLE;
            ringing_q <= 1'b0;
          end
        endcase
      end
    end
  end
`endif

  assign H           = h_q;
  assign ringing     = ringing_q;
  assign time_hh     = hh_q;
  assign time_mm     = mm_q;
  assign bad_load    = bad_load_q;
  assign sched_state = state_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Self-checking bench for alarm_scheduler: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model
// that tracks time as a single tick count within the day.
module tb_alarm_scheduler;

  localparam int T   = 4;    // ticks per minute (short so a full day fits)
  localparam int TO  = 10;
  localparam int SN  = 5;
  localparam int DAY = 1440;

`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  localparam int S_IDLE = 0, S_ARMED = 1, S_RING = 2, S_SNZ = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick, arm, load_time, load_alarm, dismiss, snooze;
  logic [4:0] set_hh;
  logic [5:0] set_mm;
  logic       H, ringing, bad_load;
  logic [4:0] time_hh;
  logic [5:0] time_mm;
  logic [1:0] sched_state;

  alarm_scheduler #(
    .TICKS_PER_MIN(T),
    .TIMEOUT_MIN  (TO),
    .SNOOZE_MIN   (SN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .arm        (arm),
    .load_time  (load_time),
    .load_alarm (load_alarm),
    .set_hh     (set_hh),
    .set_mm     (set_mm),
    .dismiss    (dismiss),
    .snooze     (snooze),
    .H          (H),
    .ringing    (ringing),
    .time_hh    (time_hh),
    .time_mm    (time_mm),
    .bad_load   (bad_load),
    .sched_state(sched_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int h_seen = 0;

  // Reference model state
  int m_pos;       // ticks since midnight, 0 .. DAY*T-1
  int m_alarm;     // alarm minute of day
  int m_state;
  int m_rung;      // minute events seen while ringing
  int m_snoozed;   // minute events seen while snoozing
  bit m_h, m_bad;

  function automatic void model_step();
    bit ok, min_evt, match;
    if (rst) begin
      m_pos = 0; m_alarm = 0; m_state = S_IDLE;
      m_rung = 0; m_snoozed = 0; m_h = 0; m_bad = 0;
      return;
    end
    ok      = (int'(set_hh) <= 23) && (int'(set_mm) <= 59);
    m_bad   = (load_time || load_alarm) && !ok;
    min_evt = 1'b0;
    if (load_time && ok) begin
      m_pos = (int'(set_hh) * 60 + int'(set_mm)) * T;
    end else if (tick) begin
      m_pos   = (m_pos + 1) % (DAY * T);
      min_evt = (m_pos % T) == 0;
    end
    match = min_evt && ((m_pos / T) == m_alarm);
    if (load_alarm && ok) m_alarm = int'(set_hh) * 60 + int'(set_mm);
    m_h = 1'b0;
    if (!arm) begin
      m_state = S_IDLE;
    end else if (m_state == S_IDLE) begin
      m_state = S_ARMED;
    end else if (m_state == S_ARMED) begin
      if (match) begin m_state = S_RING; m_h = 1'b1; m_rung = 0; end
    end else if (m_state == S_RING) begin
      if (dismiss) m_state = S_ARMED;
      else if (snooze && SNZ_EN) begin m_state = S_SNZ; m_snoozed = 0; end
      else if (min_evt) begin
        m_rung++;
        if (m_rung == TO) m_state = S_ARMED;
      end
    end else begin
      if (dismiss) m_state = S_ARMED;
      else if (min_evt) begin
        m_snoozed++;
        if (m_snoozed == SN) begin m_state = S_RING; m_h = 1'b1; m_rung = 0; end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("H", H, m_h);
    chk("ringing", ringing, (m_state == S_RING));
    chk("sched_state", sched_state, m_state);
    chk("time_hh", time_hh, (m_pos / T) / 60);
    chk("time_mm", time_mm, (m_pos / T) % 60);
    chk("bad_load", bad_load, m_bad);
    if (H === 1'b1) h_seen++;
  endtask

  // One clock: model consumes the driven inputs, DUT samples them at the
  // edge, outputs are compared 1 ns later, then pulse inputs drop.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    $display("cyc t=%0t tick=%0b arm=%0b lt=%0b la=%0b dis=%0b snz=%0b -> H=%0b st=%0d %0d:%0d bad=%0b",
             $time, tick, arm, load_time, load_alarm, dismiss, snooze,
             H, sched_state, time_hh, time_mm, bad_load);
    tick = 0; load_time = 0; load_alarm = 0; dismiss = 0; snooze = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
  endtask

  task automatic load_t(input int hh, input int mm);
    set_hh = 5'(hh); set_mm = 6'(mm); load_time = 1'b1;
    cyc();
  endtask

  task automatic load_a(input int hh, input int mm);
    set_hh = 5'(hh); set_mm = 6'(mm); load_alarm = 1'b1;
    cyc();
  endtask

  initial begin
    rst = 1; tick = 0; arm = 0; load_time = 0; load_alarm = 0;
    dismiss = 0; snooze = 0; set_hh = 0; set_mm = 0;
    cyc();
    cyc();
    chk("reset_state", sched_state, 0);
    chk("reset_H", H, 0);
    rst = 0;

    // Basic ring at 08:00
    load_t(7, 59);
    load_a(8, 0);
    arm = 1;
    cyc();
    chk("armed", sched_state, S_ARMED);
    ticks(T);
    chk("ring_H", H, 1);
    chk("ring_hh", time_hh, 8);
    chk("ring_mm", time_mm, 0);
    chk("ring_state", sched_state, S_RING);
    cyc();
    chk("H_one_cycle", H, 0);

    // Dismiss, then a full day later it rings again
    dismiss = 1;
    cyc();
    chk("dismiss_state", sched_state, S_ARMED);
    chk("dismiss_ringing", ringing, 0);
    h_seen = 0;
    ticks(DAY * T);
    chk("day_repeat_state", sched_state, S_RING);

    // Auto-timeout after TO minute events with a single H pulse
    ticks((TO - 1) * T);
    chk("pre_timeout_state", sched_state, S_RING);
    ticks(T);
    chk("timeout_state", sched_state, S_ARMED);
    chk("timeout_H_count", h_seen, 1);

    // Snooze behaviour
    load_t(7, 59);
    ticks(T);
    chk("snz_ring", sched_state, S_RING);
    snooze = 1;
    cyc();
`ifdef ALARM_SNOOZE_EN
    chk("snz_enter", sched_state, S_SNZ);
    ticks((SN - 1) * T);
    chk("snz_wait", sched_state, S_SNZ);
    ticks(T);
    chk("snz_reH", H, 1);
    chk("snz_rering", sched_state, S_RING);
    snooze = 1;
    cyc();
    chk("snz_again", sched_state, S_SNZ);
    dismiss = 1;
    cyc();
    chk("snz_dismiss", sched_state, S_ARMED);
`else
    chk("snz_ignored", sched_state, S_RING);
    dismiss = 1;
    cyc();
    chk("snz_off_dismiss", sched_state, S_ARMED);
`endif

    // Bad loads leave targets unchanged
    load_a(24, 0);
    chk("bad_alarm_flag", bad_load, 1);
    cyc();
    chk("bad_flag_once", bad_load, 0);
    load_t(12, 60);
    chk("bad_time_flag", bad_load, 1);
    load_t(7, 59);
    ticks(T);
    chk("alarm_kept_H", H, 1);
    dismiss = 1;
    cyc();

    // load_time coincident with tick: seconds cleared, tick dropped
    ticks(2);
    set_hh = 10; set_mm = 30; load_time = 1; tick = 1;
    cyc();
    chk("ld_tick_mm", time_mm, 30);
    ticks(T - 1);
    chk("ld_tick_hold", time_mm, 30);
    ticks(1);
    chk("ld_tick_adv", time_mm, 31);

    // Midnight wrap
    load_t(23, 59);
    ticks(T - 1);
    chk("pre_wrap_mm", time_mm, 59);
    ticks(1);
    chk("wrap_hh", time_hh, 0);
    chk("wrap_mm", time_mm, 0);

    // load_alarm at the matching edge uses the old alarm time
    load_t(7, 59);
    ticks(T - 1);
    set_hh = 9; set_mm = 0; load_alarm = 1; tick = 1;
    cyc();
    chk("old_alarm_H", H, 1);

    // arm=0 mid-ring
    arm = 0;
    cyc();
    chk("disarm_state", sched_state, S_IDLE);
    chk("disarm_ringing", ringing, 0);
    arm = 1;
    cyc();
    load_a(8, 0);

    // Reset mid-ring
    load_t(7, 59);
    ticks(T);
    chk("pre_rst_ring", ringing, 1);
    rst = 1; tick = 1;
    cyc();
    chk("rst_ring_state", sched_state, 0);
    chk("rst_ring_H", H, 0);
    rst = 0;
    cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 999) < 2);
      arm     = ($urandom_range(0, 99) < 97);
      tick    = $urandom_range(0, 1);
      dismiss = ($urandom_range(0, 99) < 2);
      snooze  = ($urandom_range(0, 99) < 3);
      set_hh  = 5'($urandom_range(0, 23));
      set_mm  = 6'($urandom_range(0, 59));
      if ($urandom_range(0, 99) < 3) begin
        load_alarm = 1;
        set_hh = 5'(((m_pos / T + $urandom_range(1, 3)) % DAY) / 60);
        set_mm = 6'(((m_pos / T + $urandom_range(1, 3)) % DAY) % 60);
      end
      if ($urandom_range(0, 199) < 1) load_time = 1;
      if ($urandom_range(0, 99) < 10) begin
        if ($urandom_range(0, 1) == 1) set_hh = 5'($urandom_range(24, 31));
        else set_mm = 6'($urandom_range(60, 63));
      end
      // A rejected time load coinciding with a tick is left out of the mix.
      if (load_time && (set_hh > 23 || set_mm > 59)) tick = 0;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
